vector_issue_sequencer: RTL and testbench

Parametrised front end for the vector accelerator. It buffers APU requests in a small instruction queue, classifies each instruction, and splits it into per-beat micro-ops of up to NUM_LANES elements with per-beat register addresses and active-lane count. It retires each instruction on the APU response channel. It sits between the APU interface and the per-op control decode, PE array and VLSU, and handles back-to-back issue, downstream and VLSU back-pressure, wrap-around register addressing and widening destinations.

---
 rtl/vector_issue_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_vector_issue_sequencer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_issue_sequencer.sv
// Vector issue sequencer: buffers APU requests in a small FIFO, classifies each
// instruction and splits it into per-beat micro-ops with per-beat register
// addresses and active-lane counts, then retires it on the APU response channel.
module vector_issue_sequencer #(
  parameter int unsigned NUM_LANES   = 4,
  parameter int unsigned VL_WIDTH    = 5,
  parameter int unsigned QUEUE_DEPTH = 2,
  parameter int unsigned LANE_W      = $clog2(NUM_LANES + 1)
) (
  input  logic                 clk,
  input  logic                 n_reset,
  input  logic                 apu_req,
  output logic                 apu_gnt,
  input  logic [2:0][31:0]     apu_operands,
  output logic                 apu_rvalid,
  output logic                 apu_illegal,
  input  logic [VL_WIDTH-1:0]  vl,
  input  logic                 vlsu_ready,
  input  logic                 uop_ready,
  output logic                 uop_valid,
  output logic [2:0]           uop_class,
  output logic [31:0]          uop_instr,
  output logic [31:0]          uop_scalar1,
  output logic [31:0]          uop_scalar2,
  output logic [4:0]           uop_vs1,
  output logic [4:0]           uop_vs2,
  output logic [4:0]           uop_vd,
  output logic [LANE_W-1:0]    uop_lanes,
  output logic                 uop_first,
  output logic                 uop_last
);

  localparam int unsigned PtrW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(QUEUE_DEPTH + 1);

  localparam logic [2:0] ClsCfg     = 3'd0;
  localparam logic [2:0] ClsLoad    = 3'd1;
  localparam logic [2:0] ClsArith   = 3'd2;
  localparam logic [2:0] ClsReduce  = 3'd3;
  localparam logic [2:0] ClsWiden   = 3'd4;
  // Internal-only code; never presented with uop_valid.
  localparam logic [2:0] ClsIllegal = 3'd7;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StResp  = 2'd2;

  localparam logic [6:0] OpV    = 7'b1010111;
  localparam logic [6:0] LoadFp = 7'b0000111;

  function automatic logic [2:0] classify(input logic [31:0] instr);
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [5:0] funct6;
    opcode = instr[6:0];
    funct3 = instr[14:12];
    funct6 = instr[31:26];
    if (opcode == LoadFp) begin
      return (funct3 == 3'b111) ? ClsLoad : ClsIllegal;
    end else if (opcode == OpV) begin
      if (funct3 == 3'b111) return ClsCfg;
      if (funct3 == 3'b010 && (funct6 == 6'b000000 || funct6 == 6'b000111)) return ClsReduce;
      if (funct6 == 6'b110001) return ClsReduce;
      if (funct6 == 6'b111011) return ClsWiden;
      return ClsArith;
    end
    return ClsIllegal;
  endfunction

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(QUEUE_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Instruction queue
  logic [2:0][31:0] queue_q [QUEUE_DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             q_full, q_empty, push, pop;
  logic [2:0][31:0] head;
  logic [2:0]       head_cls;

  assign q_full   = (count_q == CntW'(QUEUE_DEPTH));
  assign q_empty  = (count_q == '0);
  assign apu_gnt  = ~q_full;
  assign push     = apu_req & apu_gnt;
  assign head     = queue_q[rd_ptr_q];
  assign head_cls = classify(head[0]);

  // Queue storage; contents only matter once count covers them, so no reset.
  always_ff @(posedge clk) begin
    if (push) queue_q[wr_ptr_q] <= apu_operands;
  end

  // Queue pointers and occupancy
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (!push && pop) count_q <= count_q - 1'b1;
    end
  end

  // Executing instruction
  logic [1:0]          state_q, state_d;
  logic [31:0]         instr_q, rs1_q, rs2_q;
  logic [2:0]          cls_q;
  logic                illegal_q, first_q;
  logic [VL_WIDTH-1:0] rem_q;
  logic [4:0]          k_q;
  logic                accept, last_beat;
  logic [1:0]          start_state;

  assign uop_valid = (state_q == StIssue);
  assign accept    = uop_valid & uop_ready & ((cls_q != ClsLoad) | vlsu_ready);
  assign last_beat = (cls_q == ClsCfg) | (32'(rem_q) <= NUM_LANES);

  // Illegal or empty-vl instructions skip straight to the response.
  assign start_state = ((head_cls == ClsIllegal) || (head_cls != ClsCfg && vl == '0)) ?
                       StResp : StIssue;

  // Next-state and head-pop decision
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!q_empty) begin
          pop     = 1'b1;
          state_d = start_state;
        end
      end
      StIssue: begin
        if (accept && last_beat) state_d = StResp;
      end
      StResp: begin
        if (!q_empty) begin
          pop     = 1'b1;
          state_d = start_state;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM state
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) state_q <= StIdle;
    else          state_q <= state_d;
  end

  // Exec registers: loaded on pop, beat counter stepped on each non-final accept
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      instr_q   <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      cls_q     <= ClsCfg;
      illegal_q <= 1'b0;
      rem_q     <= '0;
      k_q       <= '0;
      first_q   <= 1'b0;
    end else if (pop) begin
      instr_q   <= head[0];
      rs1_q     <= head[1];
      rs2_q     <= head[2];
      cls_q     <= head_cls;
      illegal_q <= (head_cls == ClsIllegal);
      rem_q     <= vl;
      k_q       <= '0;
      first_q   <= 1'b1;
    end else if (accept && !last_beat) begin
      rem_q   <= rem_q - VL_WIDTH'(NUM_LANES);
      k_q     <= k_q + 5'd1;
      first_q <= 1'b0;
    end
  end

  // Beat outputs derived from exec registers and beat index
  always_comb begin
    uop_vs1 = instr_q[19:15] + k_q;
    uop_vs2 = instr_q[24:20] + k_q;
    uop_vd  = instr_q[11:7] + k_q;
    if (cls_q == ClsReduce) begin
      uop_vs1 = instr_q[19:15];
      uop_vs2 = instr_q[24:20];
      uop_vd  = instr_q[11:7];
    end else if (cls_q == ClsWiden) begin
      uop_vd = instr_q[11:7] + {k_q[3:0], 1'b0};
    end
    if (cls_q == ClsCfg)                  uop_lanes = '0;
    else if (32'(rem_q) >= NUM_LANES)     uop_lanes = LANE_W'(NUM_LANES);
    else                                  uop_lanes = LANE_W'(rem_q);
  end

  assign uop_class   = cls_q;
  assign uop_instr   = instr_q;
  assign uop_scalar1 = rs1_q;
  assign uop_scalar2 = rs2_q;
  assign uop_first   = uop_valid & first_q;
  assign uop_last    = uop_valid & last_beat;
  assign apu_rvalid  = (state_q == StResp);
  assign apu_illegal = apu_rvalid & illegal_q;

endmodule

// File: tb/tb_vector_issue_sequencer.sv
// Directed bench for vector_issue_sequencer (NUM_LANES=4, VL_WIDTH=5, QUEUE_DEPTH=2).
module tb_vector_issue_sequencer;

  logic            clk = 1'b0;
  logic            n_reset;
  logic            apu_req;
  logic            apu_gnt;
  logic [2:0][31:0] apu_operands;
  logic            apu_rvalid, apu_illegal;
  logic [4:0]      vl;
  logic            vlsu_ready, uop_ready, uop_valid;
  logic [2:0]      uop_class;
  logic [31:0]     uop_instr, uop_scalar1, uop_scalar2;
  logic [4:0]      uop_vs1, uop_vs2, uop_vd;
  logic [2:0]      uop_lanes;
  logic            uop_first, uop_last;

  int n_vec = 0;
  int n_err = 0;

  vector_issue_sequencer #(
    .NUM_LANES  (4),
    .VL_WIDTH   (5),
    .QUEUE_DEPTH(2)
  ) dut (
    .clk         (clk),
    .n_reset     (n_reset),
    .apu_req     (apu_req),
    .apu_gnt     (apu_gnt),
    .apu_operands(apu_operands),
    .apu_rvalid  (apu_rvalid),
    .apu_illegal (apu_illegal),
    .vl          (vl),
    .vlsu_ready  (vlsu_ready),
    .uop_ready   (uop_ready),
    .uop_valid   (uop_valid),
    .uop_class   (uop_class),
    .uop_instr   (uop_instr),
    .uop_scalar1 (uop_scalar1),
    .uop_scalar2 (uop_scalar2),
    .uop_vs1     (uop_vs1),
    .uop_vs2     (uop_vs2),
    .uop_vd      (uop_vd),
    .uop_lanes   (uop_lanes),
    .uop_first   (uop_first),
    .uop_last    (uop_last)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0]      instr;
    logic [4:0]       vl;
    logic [2:0]       cls;
    logic             ill;
    logic [1:0]       nb;
    logic [0:2][2:0]  lanes;
    logic [0:2][4:0]  vs1;
    logic [0:2][4:0]  vs2;
    logic [0:2][4:0]  vd;
  } vec_t;

  vec_t tbl [8];

  function automatic logic [31:0] enc(input logic [5:0] f6, input logic [2:0] f3,
                                      input logic [4:0] rd, input logic [4:0] r1,
                                      input logic [4:0] r2, input logic [6:0] op);
    return {f6, 1'b1, r2, r1, f3, rd, op};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    @(negedge clk);
    apu_req         = 1'b1;
    apu_operands[0] = v.instr;
    apu_operands[1] = 32'h1000 + idx;
    apu_operands[2] = 32'h2000 + idx;
    vl              = v.vl;
    chk($sformatf("v%0d_gnt", idx), apu_gnt, 1);
    @(negedge clk);
    apu_req = 1'b0;
    chk($sformatf("v%0d_pop_cycle_valid", idx), uop_valid, 0);
    for (int b = 0; b < int'(v.nb); b++) begin
      @(negedge clk);
      chk($sformatf("v%0d_b%0d_valid", idx, b), uop_valid, 1);
      chk($sformatf("v%0d_b%0d_class", idx, b), uop_class, v.cls);
      chk($sformatf("v%0d_b%0d_lanes", idx, b), uop_lanes, v.lanes[b]);
      chk($sformatf("v%0d_b%0d_vs1", idx, b), uop_vs1, v.vs1[b]);
      chk($sformatf("v%0d_b%0d_vs2", idx, b), uop_vs2, v.vs2[b]);
      chk($sformatf("v%0d_b%0d_vd", idx, b), uop_vd, v.vd[b]);
      chk($sformatf("v%0d_b%0d_first", idx, b), uop_first, (b == 0));
      chk($sformatf("v%0d_b%0d_last", idx, b), uop_last, (b == int'(v.nb) - 1));
      chk($sformatf("v%0d_b%0d_rvalid", idx, b), apu_rvalid, 0);
      if (b == 0) begin
        chk($sformatf("v%0d_instr", idx), uop_instr, v.instr);
        chk($sformatf("v%0d_scalar1", idx), uop_scalar1, 32'h1000 + idx);
        chk($sformatf("v%0d_scalar2", idx), uop_scalar2, 32'h2000 + idx);
      end
    end
    @(negedge clk);
    chk($sformatf("v%0d_rvalid", idx), apu_rvalid, 1);
    chk($sformatf("v%0d_illegal", idx), apu_illegal, v.ill);
    chk($sformatf("v%0d_resp_valid", idx), uop_valid, 0);
    @(negedge clk);
    chk($sformatf("v%0d_rvalid_once", idx), apu_rvalid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic       g [4];
    logic [4:0] order [$];
    int         rcnt;
    logic       early;
    logic       bad;

    tbl[0] = '{instr: enc(6'b000000, 3'b000, 5'd8, 5'd24, 5'd16, 7'h57), vl: 5'd10,
               cls: 3'd2, ill: 1'b0, nb: 2'd3, lanes: '{3'd4, 3'd4, 3'd2},
               vs1: '{5'd24, 5'd25, 5'd26}, vs2: '{5'd16, 5'd17, 5'd18},
               vd: '{5'd8, 5'd9, 5'd10}};
    tbl[1] = '{instr: enc(6'b000000, 3'b010, 5'd3, 5'd5, 5'd9, 7'h57), vl: 5'd7,
               cls: 3'd3, ill: 1'b0, nb: 2'd2, lanes: '{3'd4, 3'd3, 3'd0},
               vs1: '{5'd5, 5'd5, 5'd0}, vs2: '{5'd9, 5'd9, 5'd0},
               vd: '{5'd3, 5'd3, 5'd0}};
    tbl[2] = '{instr: enc(6'b111011, 3'b010, 5'd30, 5'd2, 5'd4, 7'h57), vl: 5'd12,
               cls: 3'd4, ill: 1'b0, nb: 2'd3, lanes: '{3'd4, 3'd4, 3'd4},
               vs1: '{5'd2, 5'd3, 5'd4}, vs2: '{5'd4, 5'd5, 5'd6},
               vd: '{5'd30, 5'd0, 5'd2}};
    tbl[3] = '{instr: enc(6'b000000, 3'b000, 5'd30, 5'd1, 5'd31, 7'h57), vl: 5'd12,
               cls: 3'd2, ill: 1'b0, nb: 2'd3, lanes: '{3'd4, 3'd4, 3'd4},
               vs1: '{5'd1, 5'd2, 5'd3}, vs2: '{5'd31, 5'd0, 5'd1},
               vd: '{5'd30, 5'd31, 5'd0}};
    tbl[4] = '{instr: enc(6'b000000, 3'b111, 5'd1, 5'd2, 5'd0, 7'h57), vl: 5'd0,
               cls: 3'd0, ill: 1'b0, nb: 2'd1, lanes: '{3'd0, 3'd0, 3'd0},
               vs1: '{5'd2, 5'd0, 5'd0}, vs2: '{5'd0, 5'd0, 5'd0},
               vd: '{5'd1, 5'd0, 5'd0}};
    tbl[5] = '{instr: enc(6'b000000, 3'b000, 5'd1, 5'd2, 5'd3, 7'h57), vl: 5'd0,
               cls: 3'd2, ill: 1'b0, nb: 2'd0, lanes: '{3'd0, 3'd0, 3'd0},
               vs1: '{5'd0, 5'd0, 5'd0}, vs2: '{5'd0, 5'd0, 5'd0},
               vd: '{5'd0, 5'd0, 5'd0}};
    tbl[6] = '{instr: enc(6'b000000, 3'b000, 5'd1, 5'd2, 5'd3, 7'h33), vl: 5'd10,
               cls: 3'd0, ill: 1'b1, nb: 2'd0, lanes: '{3'd0, 3'd0, 3'd0},
               vs1: '{5'd0, 5'd0, 5'd0}, vs2: '{5'd0, 5'd0, 5'd0},
               vd: '{5'd0, 5'd0, 5'd0}};
    tbl[7] = '{instr: enc(6'b110001, 3'b000, 5'd7, 5'd8, 5'd9, 7'h57), vl: 5'd5,
               cls: 3'd3, ill: 1'b0, nb: 2'd2, lanes: '{3'd4, 3'd1, 3'd0},
               vs1: '{5'd8, 5'd8, 5'd0}, vs2: '{5'd9, 5'd9, 5'd0},
               vd: '{5'd7, 5'd7, 5'd0}};

    n_reset      = 1'b0;
    apu_req      = 1'b0;
    apu_operands = '0;
    vl           = '0;
    vlsu_ready   = 1'b1;
    uop_ready    = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_gnt", apu_gnt, 1);
    chk("rst_uop_valid", uop_valid, 0);
    chk("rst_rvalid", apu_rvalid, 0);
    chk("rst_illegal", apu_illegal, 0);
    chk("rst_lanes", uop_lanes, 0);
    chk("rst_vd", uop_vd, 0);
    chk("rst_vs1", uop_vs1, 0);
    chk("rst_first_last", {uop_first, uop_last}, 0);
    chk("rst_class", uop_class, 0);
    chk("rst_instr", uop_instr, 0);
    n_reset = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(i, tbl[i]);

    // LOAD with a VLSU stall on beat 2 and a vl change after the snapshot
    @(negedge clk);
    apu_req         = 1'b1;
    apu_operands[0] = enc(6'b000000, 3'b111, 5'd4, 5'd10, 5'd0, 7'h07);
    apu_operands[1] = 32'hA0;
    apu_operands[2] = 32'hB0;
    vl              = 5'd8;
    @(negedge clk);
    apu_req = 1'b0;
    @(negedge clk);
    vl = 5'd3;
    chk("ld_b0_valid", uop_valid, 1);
    chk("ld_b0_class", uop_class, 1);
    chk("ld_b0_vd", uop_vd, 4);
    chk("ld_b0_vs1", uop_vs1, 10);
    chk("ld_b0_lanes", uop_lanes, 4);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      vlsu_ready = 1'b0;
      chk($sformatf("ld_stall%0d_valid", j), uop_valid, 1);
      chk($sformatf("ld_stall%0d_vd", j), uop_vd, 5);
      chk($sformatf("ld_stall%0d_vs2", j), uop_vs2, 1);
      chk($sformatf("ld_stall%0d_lanes", j), uop_lanes, 4);
      chk($sformatf("ld_stall%0d_last", j), uop_last, 1);
      chk($sformatf("ld_stall%0d_rvalid", j), apu_rvalid, 0);
    end
    @(negedge clk);
    vlsu_ready = 1'b1;
    chk("ld_b1_vd_held", uop_vd, 5);
    chk("ld_b1_first", uop_first, 0);
    @(negedge clk);
    chk("ld_rvalid", apu_rvalid, 1);
    chk("ld_resp_valid", uop_valid, 0);
    @(negedge clk);
    chk("ld_rvalid_once", apu_rvalid, 0);

    // Queue fill under downstream back-pressure
    vl        = 5'd4;
    uop_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      apu_req         = 1'b1;
      apu_operands[0] = enc(6'b000000, 3'b000, 5'(8 + i), 5'd1, 5'd2, 7'h57);
      g[i]            = apu_gnt;
    end
    chk("qf_gnt0", g[0], 1);
    chk("qf_gnt1", g[1], 1);
    chk("qf_gnt2", g[2], 1);
    chk("qf_gnt3", g[3], 0);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk($sformatf("qf_hold%0d_gnt", j), apu_gnt, 0);
      chk($sformatf("qf_hold%0d_vd", j), uop_vd, 8);
    end
    apu_req   = 1'b0;
    uop_ready = 1'b1;
    rcnt      = 0;
    early     = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (uop_valid) order.push_back(uop_vd);
      if (rcnt == 0 && apu_gnt) early = 1'b1;
      if (apu_rvalid) rcnt++;
      @(negedge clk);
    end
    chk("qf_gnt_before_retire", early, 0);
    chk("qf_retires", rcnt, 3);
    chk("qf_beats", order.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < order.size()) chk($sformatf("qf_order%0d", i), order[i], 8 + i);
      else chk($sformatf("qf_order%0d", i), 32'hFFFF, 8 + i);
    end
    chk("qf_gnt_after", apu_gnt, 1);

    // Reset mid-instruction flushes queue and suppresses retire
    vl = 5'd10;
    @(negedge clk);
    apu_req         = 1'b1;
    apu_operands[0] = enc(6'b000000, 3'b000, 5'd8, 5'd1, 5'd2, 7'h57);
    @(negedge clk);
    @(negedge clk);
    apu_req = 1'b0;
    chk("mr_valid_before", uop_valid, 1);
    n_reset = 1'b0;
    #1;
    chk("mr_valid_in_reset", uop_valid, 0);
    chk("mr_gnt_in_reset", apu_gnt, 1);
    @(negedge clk);
    n_reset = 1'b1;
    bad     = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (apu_rvalid || uop_valid) bad = 1'b1;
    end
    chk("mr_no_activity", bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
